// File: rtl/pwm_shadow_update_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_shadow_update_ctrl
//
// Sequences safe reloads of the PWM period/compare values. Software writes land
// in a shadow bank; a commit arms a transfer into the active bank, which is
// performed at the next carrier event (zero/top) that the count and mask modes
// leave unmasked. With the PWM switched off the transfer happens on the cycle
// after the commit. Every reload pulses o_update and feeds an event divider
// that raises a sticky interrupt.
//
// Ports
//   clk, rstn      system clock, asynchronous active-low reset
//   i_pwm_onoff    0 = PWM off (reload immediately), 1 = PWM on
//   i_count_mode   0 up, 1 down, 2 up/down, 3 treated as up
//   i_mask_mode    bit0 masks the zero event, bit1 masks the top event
//   i_zero, i_top  carrier min/max 1-cycle pulses
//   i_wr_en/sel/data  shadow write port (sel 0 = period, k = compare k-1)
//   i_commit       arm a transfer of the shadow bank
//   i_int_onoff    interrupt counting enable
//   i_int_div      interrupt every i_int_div+1 reloads
//   i_irq_clr      clears o_irq and o_ovf (a simultaneous set wins)
//   o_period/o_cmp active bank (compare channel 0 in the LSBs of o_cmp)
//   o_update       1-cycle pulse after the active bank was reloaded
//   o_pending      high while a commit is armed
//   o_irq          sticky divided reload interrupt
//   o_ovf          sticky: write or commit rejected while armed
// -----------------------------------------------------------------------------
module pwm_shadow_update_ctrl #(
   parameter int PWMCOUNT_WIDTH = 16,
   parameter int INTCOUNT_WIDTH = 3,
   parameter int N_CH           = 3
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             i_pwm_onoff,
   input  logic [1:0]                       i_count_mode,
   input  logic [1:0]                       i_mask_mode,
   input  logic                             i_zero,
   input  logic                             i_top,
   input  logic                             i_wr_en,
   input  logic [$clog2(N_CH+1)-1:0]        i_wr_sel,
   input  logic [PWMCOUNT_WIDTH-1:0]        i_wr_data,
   input  logic                             i_commit,
   input  logic                             i_int_onoff,
   input  logic [INTCOUNT_WIDTH-1:0]        i_int_div,
   input  logic                             i_irq_clr,
   output logic [PWMCOUNT_WIDTH-1:0]        o_period,
   output logic [N_CH*PWMCOUNT_WIDTH-1:0]   o_cmp,
   output logic                             o_update,
   output logic                             o_pending,
   output logic                             o_irq,
   output logic                             o_ovf
);

   localparam int SEL_W = $clog2(N_CH + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } state_e;

   state_e state_q, state_d;

   logic [PWMCOUNT_WIDTH-1:0]            shadow_period_q, shadow_period_d;
   logic [N_CH-1:0][PWMCOUNT_WIDTH-1:0]  shadow_cmp_q, shadow_cmp_d;
   logic [PWMCOUNT_WIDTH-1:0]            period_q, period_d;
   logic [N_CH-1:0][PWMCOUNT_WIDTH-1:0]  cmp_q, cmp_d;
   logic                                 update_q, update_d;
   logic                                 pending_q, pending_d;
   logic                                 irq_q, irq_d;
   logic                                 ovf_q, ovf_d;
   logic [INTCOUNT_WIDTH-1:0]            int_cnt_q, int_cnt_d;

   logic load_evt_s;
   logic reload_s;

   // Carrier event qualification: decides whether an armed transfer may fire now.
   always_comb begin
      load_evt_s = 1'b0;
      if (!i_pwm_onoff) begin
         // Carrier stopped: nothing to glitch, reload straight away.
         load_evt_s = 1'b1;
      end else begin
         case (i_count_mode)
            2'd2: begin
               // Up/down carrier: both turning points are candidate reload points.
               load_evt_s = (i_zero & ~i_mask_mode[0]) | (i_top & ~i_mask_mode[1]);
            end
            default: begin
               // Sawtooth carriers only reload at the wrap (zero) point.
               load_evt_s = i_zero & ~i_mask_mode[0];
            end
         endcase
      end
   end

   // Next-state logic: FSM, shadow/active banks, overflow flag and interrupt divider.
   always_comb begin
      state_d         = state_q;
      shadow_period_d = shadow_period_q;
      shadow_cmp_d    = shadow_cmp_q;
      period_d        = period_q;
      cmp_d           = cmp_q;
      update_d        = 1'b0;
      irq_d           = irq_q;
      ovf_d           = ovf_q;
      int_cnt_d       = int_cnt_q;
      reload_s        = 1'b0;

      // Clear first so that a set in the same cycle overrides it.
      if (i_irq_clr) begin
         irq_d = 1'b0;
         ovf_d = 1'b0;
      end else begin
         irq_d = irq_q;
         ovf_d = ovf_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_wr_en) begin
               if (i_wr_sel == {SEL_W{1'b0}}) begin
                  shadow_period_d = i_wr_data;
               end else begin
                  // Selects beyond the last channel match no entry and are dropped.
                  for (int k = 0; k < N_CH; k++) begin
                     if (i_wr_sel == SEL_W'(k + 1)) begin
                        shadow_cmp_d[k] = i_wr_data;
                     end else begin
                        shadow_cmp_d[k] = shadow_cmp_d[k];
                     end
                  end
               end
            end else begin
               shadow_period_d = shadow_period_q;
            end
            // The shadow registers update on this same edge, so a write issued
            // together with the commit is part of the transfer.
            if (i_commit) begin
               state_d = ST_ARMED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (i_wr_en | i_commit) begin
               ovf_d = 1'b1;
            end else begin
               ovf_d = ovf_d;
            end
            if (load_evt_s) begin
               state_d  = ST_IDLE;
               period_d = shadow_period_q;
               cmp_d    = shadow_cmp_q;
               update_d = 1'b1;
               reload_s = 1'b1;
            end else begin
               state_d = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reload event divider; held at zero while interrupts are disabled.
      if (!i_int_onoff) begin
         int_cnt_d = {INTCOUNT_WIDTH{1'b0}};
      end else if (reload_s) begin
         if (int_cnt_q == i_int_div) begin
            irq_d     = 1'b1;
            int_cnt_d = {INTCOUNT_WIDTH{1'b0}};
         end else begin
            int_cnt_d = int_cnt_q + {{(INTCOUNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end else begin
         int_cnt_d = int_cnt_q;
      end

      pending_d = (state_d == ST_ARMED);
   end

   // State and output registers; reset drops any armed commit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= ST_IDLE;
         shadow_period_q <= {PWMCOUNT_WIDTH{1'b0}};
         shadow_cmp_q    <= '0;
         period_q        <= {PWMCOUNT_WIDTH{1'b0}};
         cmp_q           <= '0;
         update_q        <= 1'b0;
         pending_q       <= 1'b0;
         irq_q           <= 1'b0;
         ovf_q           <= 1'b0;
         int_cnt_q       <= {INTCOUNT_WIDTH{1'b0}};
      end else begin
         state_q         <= state_d;
         shadow_period_q <= shadow_period_d;
         shadow_cmp_q    <= shadow_cmp_d;
         period_q        <= period_d;
         cmp_q           <= cmp_d;
         update_q        <= update_d;
         pending_q       <= pending_d;
         irq_q           <= irq_d;
         ovf_q           <= ovf_d;
         int_cnt_q       <= int_cnt_d;
      end
   end

   assign o_period  = period_q;
   assign o_cmp     = cmp_q;
   assign o_update  = update_q;
   assign o_pending = pending_q;
   assign o_irq     = irq_q;
   assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_pwm_shadow_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_shadow_update_ctrl
//
// Directed table of one-cycle vectors with hand-computed expected outputs,
// followed by hand-written sequences for the interrupt divider and for a reset
// that lands while a commit is armed.
// -----------------------------------------------------------------------------
module tb_pwm_shadow_update_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          i_pwm_onoff = 1'b0;
   logic [1:0]    i_count_mode = 2'd0;
   logic [1:0]    i_mask_mode = 2'd0;
   logic          i_zero = 1'b0;
   logic          i_top = 1'b0;
   logic          i_wr_en = 1'b0;
   logic [1:0]    i_wr_sel = 2'd0;
   logic [W-1:0]  i_wr_data = 16'd0;
   logic          i_commit = 1'b0;
   logic          i_int_onoff = 1'b0;
   logic [2:0]    i_int_div = 3'd0;
   logic          i_irq_clr = 1'b0;
   logic [W-1:0]  o_period;
   logic [3*W-1:0] o_cmp;
   logic          o_update;
   logic          o_pending;
   logic          o_irq;
   logic          o_ovf;

   int n_cmp = 0;
   int n_err = 0;

   pwm_shadow_update_ctrl #(
      .PWMCOUNT_WIDTH(16),
      .INTCOUNT_WIDTH(3),
      .N_CH(3)
   ) dut (
      .clk(clk), .rstn(rstn), .i_pwm_onoff(i_pwm_onoff),
      .i_count_mode(i_count_mode), .i_mask_mode(i_mask_mode),
      .i_zero(i_zero), .i_top(i_top), .i_wr_en(i_wr_en),
      .i_wr_sel(i_wr_sel), .i_wr_data(i_wr_data), .i_commit(i_commit),
      .i_int_onoff(i_int_onoff), .i_int_div(i_int_div), .i_irq_clr(i_irq_clr),
      .o_period(o_period), .o_cmp(o_cmp), .o_update(o_update),
      .o_pending(o_pending), .o_irq(o_irq), .o_ovf(o_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          onoff;
      logic [1:0]    mode;
      logic [1:0]    mask;
      logic          zero;
      logic          top;
      logic          wr_en;
      logic [1:0]    sel;
      logic [W-1:0]  data;
      logic          commit;
      logic          clr;
      logic          int_on;
      logic [2:0]    div;
      logic          chk_data;
      logic [W-1:0]  e_period;
      logic [3*W-1:0] e_cmp;
      logic          e_update;
      logic          e_pending;
      logic          e_irq;
      logic          e_ovf;
   } vec_t;

   localparam logic [3*W-1:0] C0 = {16'd0,   16'd0,   16'd0};
   localparam logic [3*W-1:0] CA = {16'd0,   16'd0,   16'd250};
   localparam logic [3*W-1:0] CB = {16'd0,   16'd500, 16'd250};
   localparam logic [3*W-1:0] CC = {16'd0,   16'd500, 16'd300};
   localparam logic [3*W-1:0] CD = {16'd999, 16'd500, 16'd300};

   function automatic vec_t mkv(input logic onoff, input logic [1:0] mode,
                                input logic [1:0] mask, input logic zero,
                                input logic top, input logic wr_en,
                                input logic [1:0] sel, input logic [W-1:0] data,
                                input logic commit, input logic clr,
                                input logic [W-1:0] e_period,
                                input logic [3*W-1:0] e_cmp, input logic e_upd,
                                input logic e_pend, input logic e_ovf);
      vec_t v;
      v.onoff = onoff;   v.mode = mode;     v.mask = mask;
      v.zero = zero;     v.top = top;       v.wr_en = wr_en;
      v.sel = sel;       v.data = data;     v.commit = commit;
      v.clr = clr;       v.int_on = 1'b0;   v.div = 3'd0;
      v.chk_data = 1'b1; v.e_period = e_period; v.e_cmp = e_cmp;
      v.e_update = e_upd; v.e_pending = e_pend; v.e_irq = 1'b0; v.e_ovf = e_ovf;
      return v;
   endfunction

   task automatic check(input string name, input logic [3*W-1:0] act,
                        input logic [3*W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one vector for one clock, then check the outputs 1 time unit after the edge.
   task automatic cyc(input vec_t v, input string name);
      i_pwm_onoff = v.onoff;  i_count_mode = v.mode; i_mask_mode = v.mask;
      i_zero = v.zero;        i_top = v.top;         i_wr_en = v.wr_en;
      i_wr_sel = v.sel;       i_wr_data = v.data;    i_commit = v.commit;
      i_irq_clr = v.clr;      i_int_onoff = v.int_on; i_int_div = v.div;
      @(posedge clk);
      #1;
      if (v.chk_data) begin
         check({name, ".period"}, {32'd0, o_period}, {32'd0, v.e_period});
         check({name, ".cmp"}, o_cmp, v.e_cmp);
      end
      check({name, ".update"},  {47'd0, o_update},  {47'd0, v.e_update});
      check({name, ".pending"}, {47'd0, o_pending}, {47'd0, v.e_pending});
      check({name, ".irq"},     {47'd0, o_irq},     {47'd0, v.e_irq});
      check({name, ".ovf"},     {47'd0, o_ovf},     {47'd0, v.e_ovf});
   endtask

   // One reload through commit + top in UPDOWN/no mask, with interrupts enabled.
   task automatic reload_irq(input logic [2:0] div, input logic clr_at_load,
                             input logic irq_before, input logic irq_after,
                             input string name);
      vec_t v;
      v = mkv(1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0,
              16'd0, C0, 1'b0, 1'b1, 1'b0);
      v.int_on = 1'b1; v.div = div; v.chk_data = 1'b0; v.e_irq = irq_before;
      cyc(v, {name, ".arm"});
      v = mkv(1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, clr_at_load,
              16'd0, C0, 1'b1, 1'b0, 1'b0);
      v.int_on = 1'b1; v.div = div; v.chk_data = 1'b0; v.e_irq = irq_after;
      cyc(v, {name, ".load"});
   endtask

   task automatic clr_irq(input string name);
      vec_t v;
      v = mkv(1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1,
              16'd0, C0, 1'b0, 1'b0, 1'b0);
      v.int_on = 1'b1; v.div = 3'd2; v.chk_data = 1'b0; v.e_irq = 1'b0;
      cyc(v, name);
   endtask

   vec_t tbl[$];

   initial begin
      // onoff mode mask zero top wr sel data commit clr | period cmp upd pend ovf
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,1,2'd0,16'd1000,0,0, 16'd0,   C0,0,0,0)); // 0 wr period
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,1,2'd1,16'd250, 1,0, 16'd0,   C0,0,1,0)); // 1 wr+commit
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,0,2'd0,16'd0,   0,0, 16'd0,   C0,0,1,0)); // 2 wait
      tbl.push_back(mkv(1,2'd2,2'd0,0,1,0,2'd0,16'd0,   0,0, 16'd1000,CA,1,0,0)); // 3 top loads
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,0,2'd0,16'd0,   0,0, 16'd1000,CA,0,0,0)); // 4 pulse ends
      tbl.push_back(mkv(1,2'd2,2'd2,0,0,1,2'd0,16'd2000,1,0, 16'd1000,CA,0,1,0)); // 5 MAX arm
      tbl.push_back(mkv(1,2'd2,2'd2,0,1,0,2'd0,16'd0,   0,0, 16'd1000,CA,0,1,0)); // 6 top masked
      tbl.push_back(mkv(1,2'd2,2'd2,1,0,0,2'd0,16'd0,   0,0, 16'd2000,CA,1,0,0)); // 7 zero loads
      tbl.push_back(mkv(1,2'd2,2'd3,0,0,1,2'd2,16'd500, 1,0, 16'd2000,CA,0,1,0)); // 8 MINMAX arm
      tbl.push_back(mkv(1,2'd2,2'd3,0,1,0,2'd0,16'd0,   0,0, 16'd2000,CA,0,1,0)); // 9 frozen
      tbl.push_back(mkv(1,2'd2,2'd3,1,0,0,2'd0,16'd0,   0,0, 16'd2000,CA,0,1,0)); // 10 frozen
      tbl.push_back(mkv(1,2'd2,2'd3,1,1,0,2'd0,16'd0,   0,0, 16'd2000,CA,0,1,0)); // 11 frozen
      tbl.push_back(mkv(0,2'd2,2'd3,0,0,0,2'd0,16'd0,   0,0, 16'd2000,CB,1,0,0)); // 12 PWM off
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,1,2'd1,16'd300, 1,0, 16'd2000,CB,0,1,0)); // 13 arm
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,1,2'd2,16'd77,  0,0, 16'd2000,CB,0,1,1)); // 14 wr rejected
      tbl.push_back(mkv(1,2'd2,2'd0,0,1,0,2'd0,16'd0,   0,0, 16'd2000,CC,1,0,1)); // 15 cmp1 kept
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,0,2'd0,16'd0,   0,1, 16'd2000,CC,0,0,0)); // 16 clr ovf
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,0,2'd0,16'd0,   1,0, 16'd2000,CC,0,1,0)); // 17 arm
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,0,2'd0,16'd0,   1,0, 16'd2000,CC,0,1,1)); // 18 commit rejected
      tbl.push_back(mkv(1,2'd2,2'd0,1,1,0,2'd0,16'd0,   0,0, 16'd2000,CC,1,0,1)); // 19 zero+top
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,0,2'd0,16'd0,   0,0, 16'd2000,CC,0,0,1)); // 20 single reload
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,0,2'd0,16'd0,   0,1, 16'd2000,CC,0,0,0)); // 21 clr
      tbl.push_back(mkv(1,2'd2,2'd0,0,0,1,2'd3,16'd999, 1,0, 16'd2000,CC,0,1,0)); // 22 cmp2 arm
      tbl.push_back(mkv(1,2'd2,2'd0,0,1,0,2'd0,16'd0,   0,0, 16'd2000,CD,1,0,0)); // 23 cmp2 load
      tbl.push_back(mkv(1,2'd0,2'd1,0,0,0,2'd0,16'd0,   1,0, 16'd2000,CD,0,1,0)); // 24 UP MIN arm
      tbl.push_back(mkv(1,2'd0,2'd1,1,0,0,2'd0,16'd0,   0,0, 16'd2000,CD,0,1,0)); // 25 zero masked
      tbl.push_back(mkv(1,2'd0,2'd1,0,1,0,2'd0,16'd0,   0,0, 16'd2000,CD,0,1,0)); // 26 top ignored
      tbl.push_back(mkv(1,2'd0,2'd0,0,1,0,2'd0,16'd0,   0,0, 16'd2000,CD,0,1,0)); // 27 UP top ignored
      tbl.push_back(mkv(1,2'd0,2'd0,1,0,0,2'd0,16'd0,   0,0, 16'd2000,CD,1,0,0)); // 28 UP zero loads
      tbl.push_back(mkv(1,2'd1,2'd2,0,0,1,2'd0,16'd1234,1,0, 16'd2000,CD,0,1,0)); // 29 DOWN MAX arm
      tbl.push_back(mkv(1,2'd1,2'd2,0,1,0,2'd0,16'd0,   0,0, 16'd2000,CD,0,1,0)); // 30 top ignored
      tbl.push_back(mkv(1,2'd1,2'd2,1,0,0,2'd0,16'd0,   0,0, 16'd1234,CD,1,0,0)); // 31 zero loads
      tbl.push_back(mkv(1,2'd3,2'd0,0,0,0,2'd0,16'd0,   1,0, 16'd1234,CD,0,1,0)); // 32 mode3 arm
      tbl.push_back(mkv(1,2'd3,2'd0,0,1,0,2'd0,16'd0,   0,0, 16'd1234,CD,0,1,0)); // 33 top ignored
      tbl.push_back(mkv(1,2'd3,2'd0,1,0,0,2'd0,16'd0,   0,0, 16'd1234,CD,1,0,0)); // 34 zero loads
      tbl.push_back(mkv(1,2'd2,2'd0,0,1,0,2'd0,16'd0,   0,0, 16'd1234,CD,0,0,0)); // 35 idle top

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst.period", {32'd0, o_period}, 48'd0);
      check("rst.cmp", o_cmp, 48'd0);
      check("rst.flags", {44'd0, o_update, o_pending, o_irq, o_ovf}, 48'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         cyc(tbl[i], $sformatf("vec%0d", i));
      end

      // Interrupt divider: i_int_div = 2 -> irq on every third reload.
      reload_irq(3'd2, 1'b0, 1'b0, 1'b0, "irq.r1");
      reload_irq(3'd2, 1'b0, 1'b0, 1'b0, "irq.r2");
      reload_irq(3'd2, 1'b0, 1'b0, 1'b1, "irq.r3");
      reload_irq(3'd2, 1'b0, 1'b1, 1'b1, "irq.r4");
      reload_irq(3'd2, 1'b0, 1'b1, 1'b1, "irq.r5");
      clr_irq("irq.clr1");
      reload_irq(3'd2, 1'b0, 1'b0, 1'b1, "irq.r6");
      clr_irq("irq.clr2");
      reload_irq(3'd2, 1'b0, 1'b0, 1'b0, "irq.r7");
      reload_irq(3'd2, 1'b0, 1'b0, 1'b0, "irq.r8");
      reload_irq(3'd2, 1'b1, 1'b0, 1'b1, "irq.r9_clr_set");
      clr_irq("irq.clr3");
      reload_irq(3'd0, 1'b0, 1'b0, 1'b1, "irq.div0");

      // Reset while armed: pending commit must be dropped.
      begin
         vec_t v;
         v = mkv(1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0,
                 16'd1234, CD, 1'b0, 1'b1, 1'b0);
         v.int_on = 1'b1; v.e_irq = 1'b1;
         cyc(v, "t1.arm");
         @(negedge clk);
         rstn = 1'b0;
         #1;
         check("t1.period", {32'd0, o_period}, 48'd0);
         check("t1.cmp", o_cmp, 48'd0);
         check("t1.flags", {44'd0, o_update, o_pending, o_irq, o_ovf}, 48'd0);
         @(negedge clk);
         rstn = 1'b1;
         v = mkv(1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0,
                 16'd0, C0, 1'b0, 1'b0, 1'b0);
         cyc(v, "t1.top_after");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
